dual_port_ram: RTL and testbench
================================

# dual_port_ram

True dual-port synchronous RAM with two fully independent read/write ports, A and B, on a single clock. Each port can read or write any word on any cycle. It is the storage element inside the dual-port memory subsystem, driven through the `dual_port_ram_if` interface bundle by the `test` environment. The block has fixed collision rules and a synchronous clear, so its behaviour is fully deterministic for checking.

## Interface
- `DATA_WIDTH`, 8: width of each memory word and of each data port.
- `ADDR_WIDTH`, 6: address width. Depth is 2**ADDR_WIDTH words (64 by default).

- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `addr_a`  input  ADDR_WIDTH  port A word address.
- `data_in_a`  input  DATA_WIDTH  port A write data.
- `we_a`  input  1  port A write enable; 1 = write, 0 = read.
- `data_out_a`  output  DATA_WIDTH  port A registered read data.
- `addr_b`  input  ADDR_WIDTH  port B word address.
- `data_in_b`  input  DATA_WIDTH  port B write data.
- `we_b`  input  1  port B write enable; 1 = write, 0 = read.
- `data_out_b`  output  DATA_WIDTH  port B registered read data.

## Operation
- Storage is an array of 2**ADDR_WIDTH words, each DATA_WIDTH bits.
- Each port performs exactly one access per cycle:
  - If `we_x`=1, the port writes `data_in_x` to `mem[addr_x]`.
  - On every cycle, `data_out_x` is loaded with `mem[addr_x]`, whether or not the port is writing.
- Read-first semantics:
  - `data_out_x` always returns the word's contents from before any write in the same edge.
  - This applies to a port's own write and to a write by the other port to the same address.
- Write/write collision: when `we_a`=`we_b`=1 and `addr_a`=`addr_b`, port A's data is stored and port B's write is discarded.
- Writes to different addresses on the same edge both take effect.
- Reset: while `rst`=1 at a rising edge:
  - Every memory word is cleared to 0.
  - `data_out_a` and `data_out_b` are set to 0.
  - `we_a` and `we_b` are ignored.
- No handshake: inputs are accepted every cycle, and the block has no busy state or stall.
- Addresses are always in range because they are full-width. There is no wrap or error condition.

## Timing
- Read latency is 1 cycle. An address applied before edge N produces its data on `data_out_x` after edge N, and the data is stable until edge N+1.
- A word written at edge N is readable by either port from an address presented before edge N+1. That data appears on `data_out_x` after edge N+1.
- Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset takes effect on the same edge that samples `rst`=1. The first edge with `rst`=0 performs a normal access.
- Reset asserted mid-operation abandons any write sampled on that edge.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then read addresses 0x00 and 0x3F on A and B. Both outputs read 0x00, and both outputs are 0x00 during reset.
- **Independent write/read:**
  - Stimulus: A writes 0xA5 to 0x05 while B writes 0x3C to 0x2A. Next cycle, A reads 0x2A and B reads 0x05.
  - Response: `data_out_a`=0x3C and `data_out_b`=0xA5 one cycle after the address.
- **Read-during-write, same port:**
  - Stimulus: mem[0x10]=0x11, then A writes 0x22 to 0x10.
  - Response: `data_out_a`=0x11 after that edge, and 0x22 after the following read edge.
- **Cross-port read/write collision:**
  - Stimulus: mem[0x07]=0x55. A writes 0x99 to 0x07 while B reads 0x07 on the same edge.
  - Response: `data_out_b`=0x55, and the next B read of 0x07 returns 0x99.
- **Write/write collision:**
  - Stimulus: A writes 0xF0 and B writes 0x0F to 0x20 on the same edge.
  - Response: subsequent reads on both ports return 0xF0.
- **Full sweep and mid-test reset:**
  - Stimulus: A writes addr^0x5A to all 64 addresses, then B reads all of them back. Afterwards, pulse `rst` for 1 cycle.
  - Response: B returns addr^0x5A for every address before the reset, and 0x00 at every address after it.

Source files
------------

// File: rtl/dual_port_ram_if.sv
// Signal bundle for the dual-port RAM: two independent address/data/write-enable
// ports (A and B) plus their registered read-data returns.
interface dual_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] data_out_a;

  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;
  logic                  we_b;
  logic [DATA_WIDTH-1:0] data_out_b;

  modport master (
    output addr_a, data_in_a, we_a,
    output addr_b, data_in_b, we_b,
    input  data_out_a, data_out_b
  );

  modport slave (
    input  addr_a, data_in_a, we_a,
    input  addr_b, data_in_b, we_b,
    output data_out_a, data_out_b
  );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with read-first behaviour on both ports,
// port A winning same-address write collisions, and a synchronous full clear.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input logic           clk,
  input logic           rst,
  dual_port_ram_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0]            data_out_a_q;
  logic [DATA_WIDTH-1:0]            data_out_a_d;
  logic [DATA_WIDTH-1:0]            data_out_b_q;
  logic [DATA_WIDTH-1:0]            data_out_b_d;

  // Port A is applied after port B so that on an address collision A's data lands.
  always_comb begin
    mem_d = mem_q;
    if (bus.we_b) begin
      mem_d[bus.addr_b] = bus.data_in_b;
    end
    if (bus.we_a) begin
      mem_d[bus.addr_a] = bus.data_in_a;
    end
  end

  // Reads sample the pre-edge array, giving read-first results for both ports.
  always_comb begin
    data_out_a_d = mem_q[bus.addr_a];
    data_out_b_d = mem_q[bus.addr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q        <= '0;
      data_out_a_q <= '0;
      data_out_b_q <= '0;
    end else begin
      mem_q        <= mem_d;
      data_out_a_q <= data_out_a_d;
      data_out_b_q <= data_out_b_d;
    end
  end

  assign bus.data_out_a = data_out_a_q;
  assign bus.data_out_b = data_out_b_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: a table of hand-derived vectors plus
// sweep sequences, with expected outputs queued at drive time and popped after each edge.
module tb_dual_port_ram;

  logic clk;
  logic rst;

  dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we_a;
    logic [5:0] addr_a;
    logic [7:0] din_a;
    logic       we_b;
    logic [5:0] addr_b;
    logic [7:0] din_b;
    bit         chk_a;
    logic [7:0] exp_a;
    bit         chk_b;
    logic [7:0] exp_b;
    string      name;
  } vec_t;

  typedef struct {
    bit         chk_a;
    logic [7:0] exp_a;
    bit         chk_b;
    logic [7:0] exp_b;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQueue[$];
  int   assertCount = 0;
  int   failCount   = 0;

  task automatic addVec(input logic r, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                        input logic wb, input logic [5:0] ab, input logic [7:0] db,
                        input bit ca, input logic [7:0] ea, input bit cb, input logic [7:0] eb,
                        input string nm);
    vec_t v;
    v.rst = r;   v.we_a = wa; v.addr_a = aa; v.din_a = da;
    v.we_b = wb; v.addr_b = ab; v.din_b = db;
    v.chk_a = ca; v.exp_a = ea; v.chk_b = cb; v.exp_b = eb; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst           = v.rst;
    bus.we_a      = v.we_a;
    bus.addr_a    = v.addr_a;
    bus.data_in_a = v.din_a;
    bus.we_b      = v.we_b;
    bus.addr_b    = v.addr_b;
    bus.data_in_b = v.din_b;
    e.chk_a = v.chk_a; e.exp_a = v.exp_a;
    e.chk_b = v.chk_b; e.exp_b = v.exp_b;
    e.name  = v.name;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_empty: actual size 0, required at least 1");
      return;
    end
    e = sbQueue.pop_front();
    if (e.chk_a) begin
      assertCount++;
      if (bus.data_out_a !== e.exp_a) begin
        failCount++;
        $display("[TB] FAIL %s data_out_a: actual 0x%02h, required 0x%02h", e.name, bus.data_out_a, e.exp_a);
      end
    end
    if (e.chk_b) begin
      assertCount++;
      if (bus.data_out_b !== e.exp_b) begin
        failCount++;
        $display("[TB] FAIL %s data_out_b: actual 0x%02h, required 0x%02h", e.name, bus.data_out_b, e.exp_b);
      end
    end
  endtask

  task automatic runCycle(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.we_a = 1'b0; bus.addr_a = '0; bus.data_in_a = '0;
    bus.we_b = 1'b0; bus.addr_b = '0; bus.data_in_b = '0;

    //     rst  weA  addrA  dinA   weB  addrB  dinB   chkA expA   chkB expB   name
    addVec(1'b1, 1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00, 1, 8'h00, 1, 8'h00, "reset_0");
    addVec(1'b1, 1'b1, 6'h01, 8'hEE, 1'b1, 6'h02, 8'hDD, 1, 8'h00, 1, 8'h00, "reset_1");
    addVec(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 6'h3F, 8'h00, 1, 8'h00, 1, 8'h00, "rd_after_rst_a");
    addVec(1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 6'h00, 8'h00, 1, 8'h00, 1, 8'h00, "rd_after_rst_b");
    addVec(1'b0, 1'b0, 6'h01, 8'h00, 1'b0, 6'h02, 8'h00, 1, 8'h00, 1, 8'h00, "we_ignored_rst");
    addVec(1'b0, 1'b1, 6'h05, 8'hA5, 1'b1, 6'h2A, 8'h3C, 1, 8'h00, 1, 8'h00, "indep_write");
    addVec(1'b0, 1'b0, 6'h2A, 8'h00, 1'b0, 6'h05, 8'h00, 1, 8'h3C, 1, 8'hA5, "indep_read");
    addVec(1'b0, 1'b1, 6'h10, 8'h11, 1'b0, 6'h05, 8'h00, 1, 8'h00, 1, 8'hA5, "rdw_setup");
    addVec(1'b0, 1'b1, 6'h10, 8'h22, 1'b0, 6'h10, 8'h00, 1, 8'h11, 1, 8'h11, "rdw_same_port");
    addVec(1'b0, 1'b0, 6'h10, 8'h00, 1'b0, 6'h10, 8'h00, 1, 8'h22, 1, 8'h22, "rdw_readback");
    addVec(1'b0, 1'b1, 6'h07, 8'h55, 1'b0, 6'h07, 8'h00, 1, 8'h00, 1, 8'h00, "xport_setup");
    addVec(1'b0, 1'b1, 6'h07, 8'h99, 1'b0, 6'h07, 8'h00, 1, 8'h55, 1, 8'h55, "xport_collide");
    addVec(1'b0, 1'b0, 6'h07, 8'h00, 1'b0, 6'h07, 8'h00, 1, 8'h99, 1, 8'h99, "xport_readback");
    addVec(1'b0, 1'b1, 6'h20, 8'hF0, 1'b1, 6'h20, 8'h0F, 1, 8'h00, 1, 8'h00, "ww_collide");
    addVec(1'b0, 1'b0, 6'h20, 8'h00, 1'b0, 6'h20, 8'h00, 1, 8'hF0, 1, 8'hF0, "ww_readback");
    addVec(1'b0, 1'b1, 6'h01, 8'h12, 1'b1, 6'h02, 8'h34, 1, 8'h00, 1, 8'h00, "diff_addr_wr");
    addVec(1'b0, 1'b0, 6'h02, 8'h00, 1'b0, 6'h01, 8'h00, 1, 8'h34, 1, 8'h12, "diff_addr_rd");
    addVec(1'b1, 1'b1, 6'h03, 8'h77, 1'b1, 6'h04, 8'h88, 1, 8'h00, 1, 8'h00, "mid_rst_write");
    addVec(1'b0, 1'b0, 6'h03, 8'h00, 1'b0, 6'h04, 8'h00, 1, 8'h00, 1, 8'h00, "mid_rst_abandon");
    addVec(1'b0, 1'b0, 6'h10, 8'h00, 1'b0, 6'h20, 8'h00, 1, 8'h00, 1, 8'h00, "mid_rst_cleared");

    foreach (vecs[i]) runCycle(vecs[i]);

    // Sweep: A fills every word while B reads the same word (read-first sees the cleared 0).
    for (int addr = 0; addr < 64; addr++) begin
      v = '{rst: 1'b0, we_a: 1'b1, addr_a: 6'(addr), din_a: 8'(addr) ^ 8'h5A,
            we_b: 1'b0, addr_b: 6'(addr), din_b: 8'h00,
            chk_a: 1'b0, exp_a: 8'h00, chk_b: 1'b1, exp_b: 8'h00, name: "sweep_wr"};
      runCycle(v);
    end
    for (int addr = 0; addr < 64; addr++) begin
      v = '{rst: 1'b0, we_a: 1'b0, addr_a: 6'(63 - addr), din_a: 8'h00,
            we_b: 1'b0, addr_b: 6'(addr), din_b: 8'h00,
            chk_a: 1'b1, exp_a: 8'(63 - addr) ^ 8'h5A, chk_b: 1'b1, exp_b: 8'(addr) ^ 8'h5A,
            name: "sweep_rd"};
      runCycle(v);
    end

    v = '{rst: 1'b1, we_a: 1'b0, addr_a: 6'h00, din_a: 8'h00,
          we_b: 1'b0, addr_b: 6'h00, din_b: 8'h00,
          chk_a: 1'b1, exp_a: 8'h00, chk_b: 1'b1, exp_b: 8'h00, name: "sweep_rst"};
    runCycle(v);

    for (int addr = 0; addr < 64; addr++) begin
      v = '{rst: 1'b0, we_a: 1'b0, addr_a: 6'(addr), din_a: 8'h00,
            we_b: 1'b0, addr_b: 6'(addr), din_b: 8'h00,
            chk_a: 1'b0, exp_a: 8'h00, chk_b: 1'b1, exp_b: 8'h00, name: "post_rst_rd"};
      runCycle(v);
    end

    if (sbQueue.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: actual %0d left, required 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
